// File: rtl/sweep_pkg.sv
// Shared encodings, legal frequency limits and saturating step arithmetic
// for the sweep scheduler and its testbench-facing top.
package sweep_pkg;

    localparam logic [19:0] F_MIN        = 20'd1000;
    localparam logic [19:0] F_MAX        = 20'd999999;
    localparam logic [19:0] DEFAULT_FREQ = 20'd100000;

    typedef enum logic [1:0] {
        SWP_OFF = 2'b00,
        SWP_UP  = 2'b01,
        SWP_DN  = 2'b10,
        SWP_TRI = 2'b11
    } sweep_mode_e;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN_UP,
        RUN_DN
    } sweep_state_e;

    function automatic logic [19:0] clamp_freq(input logic [20:0] f);
        if (f < {1'b0, F_MIN}) return F_MIN;
        if (f > {1'b0, F_MAX}) return F_MAX;
        return f[19:0];
    endfunction

    // Sum carried in 21 bits so the top of the legal range cannot wrap.
    function automatic logic [19:0] step_up(input logic [19:0] cur,
                                            input logic [12:0] spd,
                                            input logic [19:0] hi);
        logic [20:0] sum;
        sum = {1'b0, cur} + {8'd0, spd};
        return (sum > {1'b0, hi}) ? hi : sum[19:0];
    endfunction

    function automatic logic [19:0] step_dn(input logic [19:0] cur,
                                            input logic [12:0] spd,
                                            input logic [19:0] lo);
        return ({1'b0, cur} >= ({1'b0, lo} + {8'd0, spd})) ? (cur - {7'd0, spd}) : lo;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Step timebase: counter runs 0..TICK_DIV-1 with synchronous clear;
// tick_o is high for the one cycle the counter holds its terminal value.
module ms_tick_gen #(
    parameter int unsigned TICK_DIV = 100_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic tick_o
);
    localparam int unsigned      CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick_o = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = tick_o ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sweep_scheduler.sv
// Sweep sequencer: steps freq_cur_o once per tick between latched band edges
// (saw-up, saw-down, triangle); with sweep off it follows freq_base_i.
module sweep_scheduler
    import sweep_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 100_000_000,
    parameter int unsigned TICK_DIV = CLK_HZ / 1000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  sweep_mode_i,
    input  logic [19:0] freq_base_i,
    input  logic [16:0] sweep_range_i,
    input  logic [12:0] sweep_speed_i,
    output logic [19:0] freq_cur_o,
    output logic        freq_upd_o,
    output logic        sweeping_o,
    output logic        sweep_dir_o,
    output logic        edge_pulse_o
);
    sweep_state_e state_q;
    sweep_mode_e  mode_q;
    logic [19:0]  freq_cur_q, freq_d, lo_q, hi_q;
    logic [12:0]  spd_q;
    logic         dir_q, upd_q, sweeping_q, edge_q;
    logic         tick, mode_chg, new_off, at_edge;
    logic [19:0]  in_lo, in_hi;
    logic [20:0]  band_sum;

    assign mode_chg = (sweep_mode_i != mode_q);
    assign new_off  = (sweep_mode_i == SWP_OFF);
    assign in_lo    = clamp_freq({1'b0, freq_base_i});
    assign band_sum = {1'b0, in_lo} + {4'd0, sweep_range_i};
    assign in_hi    = (band_sum > {1'b0, F_MAX}) ? F_MAX : band_sum[19:0];

    ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (state_q == LOAD),
        .tick_o (tick)
    );

    // Band-edge events take their new target from the freshly presented band,
    // which is the same band latched on that edge.
    always_comb begin
        freq_d  = freq_cur_q;
        at_edge = 1'b0;
        case (state_q)
            IDLE: freq_d = in_lo;
            LOAD: freq_d = (mode_q == SWP_DN) ? in_hi : in_lo;
            RUN_UP: begin
                if (!mode_chg && tick) begin
                    if (freq_cur_q != hi_q) begin
                        freq_d = step_up(freq_cur_q, spd_q, hi_q);
                    end else if (lo_q != hi_q) begin
                        at_edge = 1'b1;
                        freq_d  = (mode_q == SWP_TRI) ? step_dn(in_hi, sweep_speed_i, in_lo) : in_lo;
                    end
                end
            end
            RUN_DN: begin
                if (!mode_chg && tick) begin
                    if (freq_cur_q != lo_q) begin
                        freq_d = step_dn(freq_cur_q, spd_q, lo_q);
                    end else if (lo_q != hi_q) begin
                        at_edge = 1'b1;
                        freq_d  = (mode_q == SWP_TRI) ? step_up(in_lo, sweep_speed_i, in_hi) : in_hi;
                    end
                end
            end
            default: freq_d = freq_cur_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            mode_q     <= SWP_OFF;
            freq_cur_q <= DEFAULT_FREQ;
            dir_q      <= 1'b1;
            upd_q      <= 1'b0;
            sweeping_q <= 1'b0;
            edge_q     <= 1'b0;
            lo_q       <= DEFAULT_FREQ;
            hi_q       <= DEFAULT_FREQ;
            spd_q      <= '0;
        end else begin
            mode_q     <= sweep_mode_e'(sweep_mode_i);
            freq_cur_q <= freq_d;
            upd_q      <= (freq_d != freq_cur_q) || (state_q == LOAD);
            edge_q     <= at_edge;
            sweeping_q <= 1'b0;
            if (state_q == LOAD || at_edge) begin
                lo_q  <= in_lo;
                hi_q  <= in_hi;
                spd_q <= sweep_speed_i;
            end
            case (state_q)
                IDLE: if (mode_chg && !new_off) state_q <= LOAD;
                LOAD: begin
                    dir_q <= (mode_q != SWP_DN);
                    if (mode_chg) begin
                        state_q <= new_off ? IDLE : LOAD;
                    end else begin
                        state_q    <= (mode_q == SWP_DN) ? RUN_DN : RUN_UP;
                        sweeping_q <= 1'b1;
                    end
                end
                RUN_UP: begin
                    if (mode_chg) begin
                        state_q <= new_off ? IDLE : LOAD;
                    end else begin
                        sweeping_q <= 1'b1;
                        if (at_edge && mode_q == SWP_TRI) begin
                            state_q <= RUN_DN;
                            dir_q   <= 1'b0;
                        end
                    end
                end
                RUN_DN: begin
                    if (mode_chg) begin
                        state_q <= new_off ? IDLE : LOAD;
                    end else begin
                        sweeping_q <= 1'b1;
                        if (at_edge && mode_q == SWP_TRI) begin
                            state_q <= RUN_UP;
                            dir_q   <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign freq_cur_o   = freq_cur_q;
    assign freq_upd_o   = upd_q;
    assign sweeping_o   = sweeping_q;
    assign sweep_dir_o  = dir_q;
    assign edge_pulse_o = edge_q;

endmodule

// File: tb/tb_sweep_scheduler.sv
// Self-checking bench for sweep_scheduler with a 10-clock step period.
module tb_sweep_scheduler;
    localparam int TD = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic [19:0] base;
    logic [16:0] range;
    logic [12:0] speed;
    logic [19:0] freq_cur;
    logic        freq_upd, sweeping, sweep_dir, edge_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: current frequency, direction and latched band as plain integers.
    int m_lo, m_hi, m_spd, m_cur, m_mode;
    bit m_dir;

    always #5 clk = ~clk;

    sweep_scheduler #(.TICK_DIV(TD)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .sweep_mode_i (mode),
        .freq_base_i  (base),
        .sweep_range_i(range),
        .sweep_speed_i(speed),
        .freq_cur_o   (freq_cur),
        .freq_upd_o   (freq_upd),
        .sweeping_o   (sweeping),
        .sweep_dir_o  (sweep_dir),
        .edge_pulse_o (edge_pulse)
    );

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_latch();
        m_lo  = int'(base);
        m_hi  = (int'(base) + int'(range) > 999999) ? 999999 : int'(base) + int'(range);
        m_spd = int'(speed);
    endtask

    task automatic model_load();
        model_latch();
        m_mode = int'(mode);
        m_dir  = (m_mode != 2);
        m_cur  = m_dir ? m_lo : m_hi;
    endtask

    task automatic model_tick(output bit e);
        e = 1'b0;
        if (m_lo == m_hi) return;
        if (m_dir) begin
            if (m_cur == m_hi) begin
                e = 1'b1;
                model_latch();
                if (m_mode == 3) begin
                    m_cur = (m_hi - m_spd > m_lo) ? m_hi - m_spd : m_lo;
                    m_dir = 1'b0;
                end else begin
                    m_cur = m_lo;
                end
            end else begin
                m_cur = (m_cur + m_spd < m_hi) ? m_cur + m_spd : m_hi;
            end
        end else begin
            if (m_cur == m_lo) begin
                e = 1'b1;
                model_latch();
                if (m_mode == 3) begin
                    m_cur = (m_lo + m_spd < m_hi) ? m_lo + m_spd : m_hi;
                    m_dir = 1'b1;
                end else begin
                    m_cur = m_hi;
                end
            end else begin
                m_cur = (m_cur - m_spd > m_lo) ? m_cur - m_spd : m_lo;
            end
        end
    endtask

    task automatic start_sweep(input logic [1:0] md, input int b, input int r, input int s);
        base  = 20'(b);
        range = 17'(r);
        speed = 13'(s);
        mode  = md;
        cyc(2);
        model_load();
    endtask

    task automatic go_idle();
        mode = 2'b00;
        cyc(3);
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 2'b00; base = 20'd250000; range = '0; speed = '0;
        cyc(3);
        n_checks++;
        if (freq_cur !== 20'd100000 || sweeping !== 1'b0 || sweep_dir !== 1'b1 ||
            freq_upd !== 1'b0 || edge_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: freq=%0d swp=%b dir=%b upd=%b edge=%b, want 100000 0 1 0 0",
                     freq_cur, sweeping, sweep_dir, freq_upd, edge_pulse);
        end
        rst = 1'b0;
        cyc(1);
        n_checks++;
        if (freq_cur !== 20'd250000 || freq_upd !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_track: freq=%0d upd=%b, want 250000 1", freq_cur, freq_upd);
        end
        cyc(1);
        n_checks++;
        if (freq_upd !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_upd_once: upd=%b, want 0", freq_upd);
        end
        start_sweep(2'b01, 200000, 20000, 3000);
        cyc(3 * TD);
        n_checks++;
        if (freq_cur !== 20'd209000 || sweeping !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_run: freq=%0d swp=%b, want 209000 1", freq_cur, sweeping);
        end
        rst = 1'b1; mode = 2'b00;
        cyc(1);
        n_checks++;
        if (freq_cur !== 20'd100000 || sweeping !== 1'b0 || sweep_dir !== 1'b1 ||
            freq_upd !== 1'b0 || edge_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_run: freq=%0d swp=%b dir=%b upd=%b edge=%b, want 100000 0 1 0 0",
                     freq_cur, sweeping, sweep_dir, freq_upd, edge_pulse);
        end
        rst = 1'b0; base = 20'd100000;
        cyc(2);
    endtask

    task automatic test_saw_up();
        start_sweep(2'b01, 100000, 20000, 1000);
        n_checks++;
        if (freq_cur !== 20'd100000 || freq_upd !== 1'b1 || sweeping !== 1'b1 || sweep_dir !== 1'b1) begin
            n_fail++;
            $display("FAIL saw_load: freq=%0d upd=%b swp=%b dir=%b, want 100000 1 1 1",
                     freq_cur, freq_upd, sweeping, sweep_dir);
        end
        cyc(TD - 1);
        n_checks++;
        if (freq_cur !== 20'd100000 || freq_upd !== 1'b0) begin
            n_fail++;
            $display("FAIL saw_pre_tick: freq=%0d upd=%b, want 100000 0", freq_cur, freq_upd);
        end
        for (int k = 1; k <= 21; k++) begin
            bit e;
            int prev;
            prev = m_cur;
            model_tick(e);
            cyc(k == 1 ? 1 : TD);
            n_checks++;
            if (freq_cur !== 20'(m_cur) || edge_pulse !== e || freq_upd !== (m_cur != prev)) begin
                n_fail++;
                $display("FAIL saw_tick%0d: freq=%0d edge=%b upd=%b, want %0d %b %b",
                         k, freq_cur, edge_pulse, freq_upd, m_cur, e, m_cur != prev);
            end
            if (k == 20 || k == 21) begin
                n_checks++;
                if (freq_cur !== (k == 20 ? 20'd120000 : 20'd100000) || edge_pulse !== (k == 21)) begin
                    n_fail++;
                    $display("FAIL saw_edge_tick%0d: freq=%0d edge=%b", k, freq_cur, edge_pulse);
                end
            end
        end
        go_idle();
    endtask

    task automatic test_triangle();
        start_sweep(2'b11, 100000, 20000, 1000);
        for (int k = 1; k <= 45; k++) begin
            bit e;
            int prev;
            prev = m_cur;
            model_tick(e);
            cyc(TD);
            n_checks++;
            if (freq_cur !== 20'(m_cur) || edge_pulse !== e || sweep_dir !== m_dir ||
                freq_upd !== (m_cur != prev)) begin
                n_fail++;
                $display("FAIL tri_tick%0d: freq=%0d edge=%b dir=%b upd=%b, want %0d %b %b %b",
                         k, freq_cur, edge_pulse, sweep_dir, freq_upd, m_cur, e, m_dir, m_cur != prev);
            end
            if (k == 21 || k == 41) begin
                n_checks++;
                if (freq_cur !== (k == 21 ? 20'd119000 : 20'd101000) || sweep_dir !== (k == 41) ||
                    edge_pulse !== 1'b1) begin
                    n_fail++;
                    $display("FAIL tri_turn_tick%0d: freq=%0d dir=%b edge=%b", k, freq_cur, sweep_dir, edge_pulse);
                end
            end
        end
        go_idle();
    endtask

    task automatic test_clamp();
        int exp_up[4] = '{994000, 998000, 999999, 990000};
        int exp_dn[4] = '{2000, 1000, 6000, 2000};
        start_sweep(2'b01, 990000, 20000, 4000);
        for (int k = 0; k < 4; k++) begin
            cyc(TD);
            n_checks++;
            if (freq_cur !== 20'(exp_up[k]) || edge_pulse !== (k == 3)) begin
                n_fail++;
                $display("FAIL clamp_hi_step%0d: freq=%0d edge=%b, want %0d %b",
                         k, freq_cur, edge_pulse, exp_up[k], k == 3);
            end
        end
        go_idle();
        start_sweep(2'b10, 1000, 5000, 4000);
        n_checks++;
        if (freq_cur !== 20'd6000 || sweep_dir !== 1'b0) begin
            n_fail++;
            $display("FAIL clamp_lo_load: freq=%0d dir=%b, want 6000 0", freq_cur, sweep_dir);
        end
        for (int k = 0; k < 4; k++) begin
            cyc(TD);
            n_checks++;
            if (freq_cur !== 20'(exp_dn[k]) || edge_pulse !== (k == 2)) begin
                n_fail++;
                $display("FAIL clamp_lo_step%0d: freq=%0d edge=%b, want %0d %b",
                         k, freq_cur, edge_pulse, exp_dn[k], k == 2);
            end
        end
        go_idle();
    endtask

    task automatic test_flat();
        for (int p = 0; p < 2; p++) begin
            int f;
            f = (p == 0) ? 200000 : 300000;
            if (p == 0) start_sweep(2'b01, f, 10000, 0);
            else        start_sweep(2'b11, f, 0, 1000);
            n_checks++;
            if (freq_cur !== 20'(f) || freq_upd !== 1'b1) begin
                n_fail++;
                $display("FAIL flat%0d_load: freq=%0d upd=%b, want %0d 1", p, freq_cur, freq_upd, f);
            end
            for (int c = 0; c < 3 * TD; c++) begin
                cyc(1);
                n_checks++;
                if (freq_cur !== 20'(f) || freq_upd !== 1'b0 || edge_pulse !== 1'b0 || sweeping !== 1'b1) begin
                    n_fail++;
                    $display("FAIL flat%0d_cyc%0d: freq=%0d upd=%b edge=%b swp=%b, want %0d 0 0 1",
                             p, c, freq_cur, freq_upd, edge_pulse, sweeping, f);
                end
            end
            go_idle();
        end
    endtask

    task automatic test_mode_change();
        start_sweep(2'b01, 100000, 20000, 1000);
        cyc(5 * TD);
        n_checks++;
        if (freq_cur !== 20'd105000) begin
            n_fail++;
            $display("FAIL chg_pre: freq=%0d, want 105000", freq_cur);
        end
        start_sweep(2'b10, 100000, 20000, 1000);
        n_checks++;
        if (freq_cur !== 20'd120000 || sweep_dir !== 1'b0 || freq_upd !== 1'b1 || sweeping !== 1'b1) begin
            n_fail++;
            $display("FAIL chg_reload: freq=%0d dir=%b upd=%b swp=%b, want 120000 0 1 1",
                     freq_cur, sweep_dir, freq_upd, sweeping);
        end
        for (int k = 1; k <= 3; k++) begin
            bit e;
            model_tick(e);
            cyc(TD);
            n_checks++;
            if (freq_cur !== 20'(m_cur) || edge_pulse !== e) begin
                n_fail++;
                $display("FAIL chg_dn_tick%0d: freq=%0d edge=%b, want %0d %b", k, freq_cur, edge_pulse, m_cur, e);
            end
        end
        mode = 2'b00; base = 20'd150000;
        cyc(1);
        n_checks++;
        if (sweeping !== 1'b0 || freq_cur !== 20'(m_cur)) begin
            n_fail++;
            $display("FAIL chg_off: swp=%b freq=%0d, want 0 %0d", sweeping, freq_cur, m_cur);
        end
        cyc(1);
        n_checks++;
        if (freq_cur !== 20'd150000) begin
            n_fail++;
            $display("FAIL chg_idle_base: freq=%0d, want 150000", freq_cur);
        end
        start_sweep(2'b01, 100000, 20000, 5000);
        for (int k = 1; k <= 8; k++) begin
            bit e;
            if (k == 3) range = 17'd10000;
            model_tick(e);
            cyc(TD);
            n_checks++;
            if (freq_cur !== 20'(m_cur) || edge_pulse !== e) begin
                n_fail++;
                $display("FAIL range_chg_tick%0d: freq=%0d edge=%b, want %0d %b", k, freq_cur, edge_pulse, m_cur, e);
            end
            if (k == 4) begin
                n_checks++;
                if (freq_cur !== 20'd120000) begin
                    n_fail++;
                    $display("FAIL range_held: freq=%0d, want 120000", freq_cur);
                end
            end
        end
        go_idle();
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            start_sweep(2'($urandom_range(1, 3)), int'($urandom_range(1000, 999999)),
                        int'($urandom_range(0, 20000)), int'($urandom_range(0, 4000)));
            n_checks++;
            if (freq_cur !== 20'(m_cur) || freq_upd !== 1'b1 || sweep_dir !== m_dir || sweeping !== 1'b1) begin
                n_fail++;
                $display("FAIL rnd%0d_load: freq=%0d upd=%b dir=%b swp=%b, want %0d 1 %b 1",
                         it, freq_cur, freq_upd, sweep_dir, sweeping, m_cur, m_dir);
            end
            for (int k = 1; k <= 30; k++) begin
                bit e;
                int prev;
                if (k == 12) begin
                    base  = 20'($urandom_range(1000, 999999));
                    range = 17'($urandom_range(0, 50000));
                    speed = 13'($urandom_range(0, 4000));
                end
                prev = m_cur;
                model_tick(e);
                cyc(TD);
                n_checks++;
                if (freq_cur !== 20'(m_cur) || edge_pulse !== e || sweep_dir !== m_dir ||
                    freq_upd !== (m_cur != prev) || sweeping !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rnd%0d_tick%0d: freq=%0d edge=%b dir=%b upd=%b, want %0d %b %b %b",
                             it, k, freq_cur, edge_pulse, sweep_dir, freq_upd, m_cur, e, m_dir, m_cur != prev);
                end
            end
            go_idle();
        end
    endtask

    initial begin
        test_reset();
        test_saw_up();
        test_triangle();
        test_clamp();
        test_flat();
        test_mode_change();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
